// File: rtl/drive_mode_arbiter.sv
// drive_mode_arbiter: shares one motor command bus between manual, semi-auto and auto
// requesters with a forced-stop drain on every mode change. Define AUTO_MODE_EN to build in auto.

module drive_mode_cmd_lane (
  input  logic [3:0] raw,
  output logic [3:0] clean
);
  // Left and right together is contradictory; drop both, keep back/forward.
  always_comb begin
    clean = raw;
    if (raw[3] && raw[2]) clean[3:2] = 2'b00;
  end
endmodule

module drive_mode_arbiter #(
  parameter int SETTLE_CYCLES = 16,
  parameter int BUSY_TIMEOUT  = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power_on,
  input  logic [1:0] mode_sel,
  input  logic [3:0] man_cmd,
  input  logic       man_busy,
  input  logic [3:0] semi_cmd,
  input  logic       semi_busy,
  input  logic [3:0] auto_cmd,
  input  logic       auto_busy,
  output logic       man_en,
  output logic       semi_en,
  output logic       auto_en,
  output logic [3:0] motor_cmd,
  output logic [3:0] arb_state,
  output logic [1:0] cur_mode,
  output logic       fault
);
  localparam int NUM_REQ = 3;
  localparam int SW = $clog2(SETTLE_CYCLES) + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT) + 1;

  typedef enum logic [3:0] {
    S_OFF   = 4'b0001,
    S_IDLE  = 4'b0010,
    S_GRANT = 4'b0100,
    S_DRAIN = 4'b1000
  } state_t;

  state_t                     state, state_n;
  logic [1:0]                 mode_n;
  logic [NUM_REQ-1:0]         en_q, en_n;
  logic [3:0]                 cmd_n;
  logic                       fault_n;
  logic [SW-1:0]              settle_cnt, settle_n;
  logic [TW-1:0]              tmo_cnt, tmo_n;

  logic [NUM_REQ-1:0][3:0]    req_cmd, san_cmd;
  logic [NUM_REQ-1:0]         req_busy;
  logic [3:0]                 sel_cmd;
  logic                       sel_busy;
  logic                       sel_legal;

`ifdef AUTO_MODE_EN
  localparam logic AUTO_OK = 1'b1;
  assign req_cmd  = {auto_cmd, semi_cmd, man_cmd};
  assign req_busy = {auto_busy, semi_busy, man_busy};
  assign auto_en  = en_q[2];
`else
  localparam logic AUTO_OK = 1'b0;
  logic unused_auto;
  assign req_cmd     = {4'b0000, semi_cmd, man_cmd};
  assign req_busy    = {1'b0, semi_busy, man_busy};
  assign auto_en     = 1'b0;
  assign unused_auto = ^{auto_cmd, auto_busy, en_q[2]};
`endif

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    drive_mode_cmd_lane u_lane (.raw(req_cmd[g]), .clean(san_cmd[g]));
  end

  always_comb begin
    sel_cmd  = 4'b0000;
    sel_busy = 1'b0;
    case (cur_mode)
      2'b01:   begin sel_cmd = san_cmd[0]; sel_busy = req_busy[0]; end
      2'b10:   begin sel_cmd = san_cmd[1]; sel_busy = req_busy[1]; end
      2'b11:   begin sel_cmd = san_cmd[2]; sel_busy = req_busy[2]; end
      default: begin sel_cmd = 4'b0000;    sel_busy = 1'b0;        end
    endcase
  end

  // Without auto, mode_sel=11 is simply not a request in IDLE.
  assign sel_legal = (mode_sel != 2'b00) && (AUTO_OK || (mode_sel != 2'b11));

  always_comb begin
    state_n  = state;
    mode_n   = cur_mode;
    fault_n  = fault;
    settle_n = settle_cnt;
    tmo_n    = tmo_cnt;
    case (state)
      S_OFF: begin
        fault_n  = 1'b0;
        mode_n   = 2'b00;
        settle_n = '0;
        tmo_n    = '0;
        if (power_on) state_n = S_IDLE;
      end
      S_IDLE: begin
        if (sel_legal) begin
          mode_n  = mode_sel;
          state_n = S_GRANT;
        end
      end
      S_GRANT: begin
        if (mode_sel != cur_mode) begin
          state_n  = S_DRAIN;
          settle_n = SW'(SETTLE_CYCLES - 1);
          tmo_n    = '0;
        end
      end
      S_DRAIN: begin
        if ((settle_cnt == '0) && !sel_busy) begin
          state_n = S_IDLE;
          mode_n  = 2'b00;
        end else if (tmo_cnt == TW'(BUSY_TIMEOUT - 1)) begin
          state_n = S_IDLE;
          mode_n  = 2'b00;
          fault_n = 1'b1;
        end else begin
          if (settle_cnt != '0) settle_n = settle_cnt - 1'b1;
          tmo_n = tmo_cnt + 1'b1;
        end
      end
      default: begin
        state_n = S_OFF;
        mode_n  = 2'b00;
      end
    endcase

    // Loss of power beats every other transition, including a drain exit.
    if (!power_on) begin
      state_n  = S_OFF;
      mode_n   = 2'b00;
      fault_n  = 1'b0;
      settle_n = '0;
      tmo_n    = '0;
    end

    for (int i = 0; i < NUM_REQ; i++)
      en_n[i] = (state_n == S_GRANT) && (mode_n == 2'(i + 1));
    cmd_n = ((state == S_GRANT) && (state_n == S_GRANT)) ? sel_cmd : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_OFF;
      cur_mode   <= 2'b00;
      en_q       <= '0;
      motor_cmd  <= 4'b0000;
      fault      <= 1'b0;
      settle_cnt <= '0;
      tmo_cnt    <= '0;
    end else begin
      state      <= state_n;
      cur_mode   <= mode_n;
      en_q       <= en_n;
      motor_cmd  <= cmd_n;
      fault      <= fault_n;
      settle_cnt <= settle_n;
      tmo_cnt    <= tmo_n;
    end
  end

  assign arb_state = state;
  assign man_en    = en_q[0];
  assign semi_en   = en_q[1];
endmodule

// File: tb/tb_drive_mode_arbiter.sv
// Bench for drive_mode_arbiter: directed vector table, hand sequences for drain/timeout/power,
// and a randomized run against a phase-level reference model.

module tb_drive_mode_arbiter;
  localparam int SETTLE = 16;
  localparam int BTO    = 1024;

  logic       clk = 1'b0;
  logic       rst, power_on;
  logic [1:0] mode_sel;
  logic [3:0] man_cmd, semi_cmd, auto_cmd;
  logic       man_busy, semi_busy, auto_busy;
  logic       man_en, semi_en, auto_en, fault;
  logic [3:0] motor_cmd, arb_state;
  logic [1:0] cur_mode;

  int checks = 0;
  int errors = 0;

  drive_mode_arbiter #(.SETTLE_CYCLES(SETTLE), .BUSY_TIMEOUT(BTO)) dut (
    .clk(clk), .rst(rst), .power_on(power_on), .mode_sel(mode_sel),
    .man_cmd(man_cmd), .man_busy(man_busy), .semi_cmd(semi_cmd), .semi_busy(semi_busy),
    .auto_cmd(auto_cmd), .auto_busy(auto_busy), .man_en(man_en), .semi_en(semi_en),
    .auto_en(auto_en), .motor_cmd(motor_cmd), .arb_state(arb_state), .cur_mode(cur_mode),
    .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] snap();
    return {arb_state, cur_mode, auto_en, semi_en, man_en, motor_cmd, fault};
  endfunction

  // ---------------- reference model: phases and elapsed drain time ----------------
  int         m_phase;   // 0 off, 1 idle, 2 grant, 3 drain
  int         m_mode;
  int         m_el;
  logic       m_fault;
  logic [3:0] m_cmd;
  logic [2:0] m_en;

  function automatic logic [3:0] clean(input logic [3:0] c);
    return (c[3:2] == 2'b11) ? {2'b00, c[1:0]} : c;
  endfunction

  function automatic bit auto_built();
`ifdef AUTO_MODE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_step();
    logic [3:0] rc;
    logic       rb;
    rc = (m_mode == 1) ? man_cmd : (m_mode == 2) ? semi_cmd : (m_mode == 3) ? auto_cmd : 4'b0;
    rb = (m_mode == 1) ? man_busy : (m_mode == 2) ? semi_busy : (m_mode == 3) ? auto_busy : 1'b0;
    m_cmd = 4'b0;
    m_en  = 3'b0;
    if (rst || !power_on) begin
      m_phase = 0; m_mode = 0; m_fault = 1'b0; m_el = 0;
    end else begin
      case (m_phase)
        0: m_phase = 1;
        1: if (mode_sel != 0 && (auto_built() || mode_sel != 3)) begin
             m_mode = mode_sel; m_phase = 2;
           end
        2: if (int'(mode_sel) != m_mode) begin m_phase = 3; m_el = 0; end
           else m_cmd = clean(rc);
        default: begin
          m_el++;
          if (m_el >= SETTLE && !rb) begin m_phase = 1; m_mode = 0; end
          else if (m_el >= BTO) begin m_phase = 1; m_mode = 0; m_fault = 1'b1; end
        end
      endcase
      if (m_phase == 2) m_en = 3'(1 << (m_mode - 1));
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       rst, pwr;
    logic [1:0] sel;
    logic [3:0] mc;
    logic [3:0] e_state;
    logic [1:0] e_mode;
    logic [2:0] e_en;
    logic [3:0] e_cmd;
    logic       e_fault;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int n;
    rst = 1'b1; power_on = 1'b0; mode_sel = 2'b00;
    man_cmd = '0; semi_cmd = '0; auto_cmd = '0;
    man_busy = 1'b0; semi_busy = 1'b0; auto_busy = 1'b0;

    tbl[0] = '{1'b1, 1'b0, 2'b00, 4'b0000, 4'b0001, 2'b00, 3'b000, 4'b0000, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 2'b01, 4'b0001, 4'b0010, 2'b00, 3'b000, 4'b0000, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 2'b01, 4'b0001, 4'b0100, 2'b01, 3'b001, 4'b0000, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 2'b01, 4'b0001, 4'b0100, 2'b01, 3'b001, 4'b0001, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 2'b01, 4'b1101, 4'b0100, 2'b01, 3'b001, 4'b0001, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 2'b01, 4'b1110, 4'b0100, 2'b01, 3'b001, 4'b0010, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 2'b01, 4'b1010, 4'b0100, 2'b01, 3'b001, 4'b1010, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 2'b11, 4'b1010, 4'b1000, 2'b01, 3'b000, 4'b0000, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 2'b01, 4'b1010, 4'b1000, 2'b01, 3'b000, 4'b0000, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 2'b01, 4'b1010, 4'b0001, 2'b00, 3'b000, 4'b0000, 1'b0};

    for (int i = 0; i < 10; i++) begin
      rst = tbl[i].rst; power_on = tbl[i].pwr; mode_sel = tbl[i].sel; man_cmd = tbl[i].mc;
      tick();
      chk($sformatf("vec%0d", i), 32'(snap()),
          32'({tbl[i].e_state, tbl[i].e_mode, tbl[i].e_en, tbl[i].e_cmd, tbl[i].e_fault}));
    end

    // manual -> semi with idle busy: exactly SETTLE drain cycles, one IDLE, then semi grant
    power_on = 1'b1; mode_sel = 2'b01; man_cmd = 4'b1001;
    tick(); tick(); tick();
    chk("grant_cmd_1001", 32'(motor_cmd), 32'h9);
    mode_sel = 2'b10;
    n = 0;
    tick();
    while (arb_state == 4'b1000 && n < 2000) begin
      n++;
      chk("drain_zero", 32'({motor_cmd, man_en, semi_en, auto_en}), 32'h0);
      tick();
    end
    chk("drain_len", 32'(n), 32'(SETTLE));
    chk("post_drain_idle", 32'({arb_state, cur_mode}), 32'({4'b0010, 2'b00}));
    tick();
    chk("semi_grant", 32'({arb_state, cur_mode, semi_en, man_en}), 32'({4'b0100, 2'b10, 1'b1, 1'b0}));

    // semi busy stuck: timeout after BTO drain cycles, sticky fault until OFF
    semi_busy = 1'b1; mode_sel = 2'b01;
    n = 0;
    tick();
    while (arb_state == 4'b1000 && n < 2000) begin n++; tick(); end
    chk("timeout_len", 32'(n), 32'(BTO));
    chk("timeout_fault", 32'({arb_state, cur_mode, fault}), 32'({4'b0010, 2'b00, 1'b1}));
    semi_busy = 1'b0;
    tick();
    chk("fault_sticky", 32'({arb_state, man_en, fault}), 32'({4'b0100, 1'b1, 1'b1}));
    power_on = 1'b0;
    tick();
    chk("fault_clear_off", 32'(snap()), 32'({4'b0001, 10'b0}));

    // power drop from GRANT with 1001 on the bus, then rst mid-drain
    power_on = 1'b1; mode_sel = 2'b01; man_cmd = 4'b1001;
    tick(); tick(); tick();
    chk("pre_drop_cmd", 32'(motor_cmd), 32'h9);
    power_on = 1'b0;
    tick();
    chk("power_drop", 32'(snap()), 32'({4'b0001, 10'b0}));
    power_on = 1'b1;
    tick(); tick(); tick();
    mode_sel = 2'b10; man_busy = 1'b1;
    tick(); tick();
    chk("in_drain", 32'(arb_state), 32'h8);
    rst = 1'b1;
    tick();
    chk("rst_mid_drain", 32'(snap()), 32'({4'b0001, 10'b0}));
    rst = 1'b0; man_busy = 1'b0; power_on = 1'b0;
    tick();

    // mode_sel = 11 from IDLE
    power_on = 1'b1; mode_sel = 2'b11; auto_cmd = 4'b0110;
    tick();
`ifdef AUTO_MODE_EN
    tick();
    chk("auto_grant", 32'({arb_state, cur_mode, auto_en}), 32'({4'b0100, 2'b11, 1'b1}));
    tick();
    chk("auto_cmd", 32'(motor_cmd), 32'h6);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("sel11_idle", 32'({arb_state, auto_en, cur_mode}), 32'({4'b0010, 1'b0, 2'b00}));
    end
`endif

    // randomized run against the reference model
    rst = 1'b1; power_on = 1'b0; mode_sel = 2'b00;
    model_step();
    tick();
    rst = 1'b0; power_on = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(699) == 0);
      if (power_on) power_on = ($urandom_range(299) != 0);
      else          power_on = ($urandom_range(3) == 0);
      if ($urandom_range(39) == 0) mode_sel = 2'($urandom_range(3));
      man_cmd  = 4'($urandom);
      semi_cmd = 4'($urandom);
      auto_cmd = 4'($urandom);
      if ($urandom_range(19) == 0) man_busy  = ~man_busy;
      if ($urandom_range(19) == 0) semi_busy = ~semi_busy;
      if ($urandom_range(19) == 0) auto_busy = ~auto_busy;
      model_step();
      tick();
      chk($sformatf("rand%0d", c), 32'(snap()),
          32'({4'(1 << m_phase), 2'(m_mode), m_en, m_cmd, m_fault}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/drive_mode_arbiter.md
# drive_mode_arbiter

Owns the single set of motor command lines {left, right, back, forward} and shares it between up to three driving-mode requesters: manual, semi-auto and auto. It gates everything on the power switch and grants one mode at a time. A mode change is sequenced through a forced-stop drain window, so commands from two modes never mix. It sits between the per-mode state machines and the motor/LED outputs at the top level.

## Interface
- SETTLE_CYCLES, 16: minimum number of cycles that `motor_cmd` is held at zero in DRAIN. Legal values are 1 or more.
- BUSY_TIMEOUT, 1024: maximum number of cycles in DRAIN spent waiting for the outgoing mode's busy to drop. Must be greater than SETTLE_CYCLES.

- clk  in  1  system clock, 100 MHz (P17).
- rst  in  1  synchronous, active-high reset.
- power_on  in  1  power switch level; 1 means powered.
- mode_sel  in  2  00 = none, 01 = manual, 10 = semi-auto, 11 = auto.
- man_cmd  in  4  manual command {left, right, back, forward}.
- man_busy  in  1  manual mode is not in its stopped/unstarted state.
- semi_cmd  in  4  semi-auto command, same bit order as man_cmd.
- semi_busy  in  1  semi-auto mode is executing a manoeuvre.
- auto_cmd  in  4  auto command, same bit order as man_cmd.
- auto_busy  in  1  auto mode is executing.
- man_en, semi_en, auto_en  out  1 each  grant/enable to the requesters; at most one is high.
- motor_cmd  out  4  arbitrated command {left, right, back, forward}.
- arb_state  out  4  one-hot state: OFF = 0001, IDLE = 0010, GRANT = 0100, DRAIN = 1000.
- cur_mode  out  2  latched granted mode; 00 when no mode is owned.
- fault  out  1  sticky flag: a drain was ended by timeout.

## Operation
- All outputs are registers. Reset values:
  - arb_state = 0001 (OFF)
  - cur_mode = 00
  - all grant enables = 0
  - motor_cmd = 0000
  - fault = 0
  - counters = 0
- OFF:
  - All outputs are zero, and fault is cleared in this state.
  - Moves to IDLE when power_on = 1.
- IDLE:
  - No grants are asserted and motor_cmd = 0000.
  - If mode_sel ≠ 00 and the selected mode is compiled in, latch cur_mode = mode_sel and move to GRANT.
- GRANT:
  - The enable for cur_mode is high.
  - motor_cmd = the sanitised command of the selected requester.
  - Sanitising rule: if left and right are both 1, both are cleared. The back and forward bits pass unchanged.
  - If mode_sel ≠ cur_mode, move to DRAIN.
- DRAIN:
  - All enables and motor_cmd are forced to zero, and cur_mode is held.
  - The settle counter loads SETTLE_CYCLES−1 on entry and the timeout counter loads 0.
  - Exit to IDLE happens when the settle counter is 0 AND the busy of cur_mode is 0. cur_mode clears to 00 on that exit.
  - If the timeout counter reaches BUSY_TIMEOUT−1 first, exit to IDLE anyway and set fault.
- power_on = 0 in any state forces OFF on the next edge. This has priority over every other transition, including a DRAIN exit.
- A mode_sel change back to cur_mode during DRAIN does not abort the drain; the full sequence still runs.
- rst mid-operation behaves exactly like the reset values above on the next edge, regardless of state.
- Counter widths are $clog2 of the parameter plus 1; the counters saturate and never wrap.

## Timing
- Latency from a requester's cmd to motor_cmd is 1 cycle (one register) while in GRANT.
- IDLE to first grant:
  - mode_sel is sampled at edge N.
  - arb_state = GRANT and the enable is high after edge N.
  - The first non-zero motor_cmd follows one edge later.
- DRAIN entry: motor_cmd and the enables go to zero on the same edge that arb_state becomes DRAIN.
- Minimum DRAIN duration is SETTLE_CYCLES cycles. Maximum is BUSY_TIMEOUT cycles.
- After a DRAIN exit, at least one IDLE cycle occurs before the next grant, so any two grants are separated by at least SETTLE_CYCLES+1 zero cycles.
- Power-off: everything is zero on the edge after power_on falls.

## Configuration
- AUTO_MODE_EN defined:
  - mode_sel = 11 grants auto.
  - auto_cmd and auto_busy are arbitrated like the other two modes.
- AUTO_MODE_EN undefined:
  - The auto path is not compiled in and auto_en is tied to 0.
  - mode_sel = 11 in IDLE is treated as 00 (stay in IDLE).
  - mode_sel = 11 in GRANT counts as a change and starts DRAIN.
  - The auto_* ports remain in the port list but are unused.

## Test plan
- Reset then power_on = 1, mode_sel = 01, man_cmd = 0001 → arb_state goes 0001 → 0010 → 0100; man_en = 1; motor_cmd = 0001 one cycle after GRANT.
- In GRANT (manual), man_cmd = 1101 → motor_cmd = 0001 (left and right both set, so both cleared).
- In GRANT (manual), mode_sel switches to 10 with man_busy = 0, SETTLE_CYCLES = 16 → 16 DRAIN cycles with motor_cmd = 0000, then IDLE, then GRANT with semi_en = 1 and cur_mode = 10.
- In DRAIN, man_busy is held at 1 with BUSY_TIMEOUT = 1024 → exit to IDLE after 1024 DRAIN cycles with fault = 1; fault clears only after power_on = 0 drives the block to OFF.
- In GRANT with motor_cmd = 1001, drop power_on → the next edge gives arb_state = 0001 and all outputs 0; repeat with rst = 1 mid-DRAIN → the same result.
- Build without AUTO_MODE_EN, IDLE, mode_sel = 11 held for 20 cycles → the block stays in IDLE and auto_en = 0 throughout.
